spi_frame_master: RTL and testbench



---
 rtl/spi_frame_master.sv | 148 ++++++++++++++
 tb/tb_spi_frame_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// SPI mode-0 master: serialises a word MSB-first on MOSI while capturing MISO.
// Latency: frame = CLK_DIV*(2*DATA_WIDTH+2) clocks from the accepted strobe to rx_valid.
// Backpressure: none; a strobe while busy is dropped and flagged on overrun.
module spi_frame_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_update,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCLK,
  output logic                  SS,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  overrun
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] TICK_AT  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rx_data_d;
  logic                  sclk_d, ss_d, mosi_d, busy_d, rx_valid_d, overrun_d;
  logic                  tick, start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and next values of every registered output and datapath register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data;
    sclk_d     = SCLK;
    ss_d       = SS;
    mosi_d     = MOSI;
    busy_d     = busy;
    rx_valid_d = 1'b0;
    overrun_d  = 1'b0;
    tick       = (cnt_q == TICK_AT);

    // The completion edge of HOLD may accept a new frame so frames can abut.
    start = data_update && ((state_q == IDLE) || (state_q == HOLD && tick));
    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: cnt_d = '0;
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_WIDTH-2:0], MISO};
          bit_d   = BW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (SCLK) begin
            sclk_d = 1'b0;
            if (bit_q != LAST_BIT) begin
              tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
              mosi_d = tx_q[DATA_WIDTH-2];
            end
          end else if (bit_q == LAST_BIT) begin
            // One further low half-period after the last fall before HOLD.
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_WIDTH-2:0], MISO};
            bit_d  = bit_q + BW'(1);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          ss_d       = 1'b1;
          busy_d     = 1'b0;
          mosi_d     = 1'b0;
          rx_data_d  = rx_q;
          rx_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_d = data_update && !start && (state_q != IDLE);

    if (start) begin
      tx_d    = data;
      ss_d    = 1'b0;
      busy_d  = 1'b1;
      mosi_d  = data[DATA_WIDTH-1];
      cnt_d   = '0;
      bit_d   = '0;
      sclk_d  = 1'b0;
      state_d = SETUP;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rx_data  <= '0;
      SCLK     <= 1'b0;
      SS       <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rx_data  <= rx_data_d;
      SCLK     <= sclk_d;
      SS       <= ss_d;
      MOSI     <= mosi_d;
      busy     <= busy_d;
      rx_valid <= rx_valid_d;
      overrun  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master (default and CLK_DIV=1/DATA_WIDTH=10 instances).
// Indexing: index i is observed 1 ns after edge E0+i, E0 being the edge that samples the strobe.
// Received words are scoreboarded: expected pushed at stimulus, popped on rx_valid.
module tb_spi_frame_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance.
  logic [7:0] data = '0;
  logic       data_update = 1'b0;
  logic       miso, mosi, sclk, ss, busy, rx_valid, overrun;
  logic [7:0] rx_data;
  logic       loop = 1'b1;
  logic       miso_drv = 1'b0;
  assign miso = loop ? mosi : miso_drv;

  spi_frame_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_update(data_update), .MISO(miso),
    .MOSI(mosi), .SCLK(sclk), .SS(ss), .busy(busy), .rx_data(rx_data),
    .rx_valid(rx_valid), .overrun(overrun)
  );

  // Fast, wide instance in loopback.
  logic [9:0] data2 = '0;
  logic       data_update2 = 1'b0;
  logic       mosi2, sclk2, ss2, busy2, rx_valid2, overrun2;
  logic [9:0] rx_data2;

  spi_frame_master #(.DATA_WIDTH(10), .CLK_DIV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .data(data2), .data_update(data_update2), .MISO(mosi2),
    .MOSI(mosi2), .SCLK(sclk2), .SS(ss2), .busy(busy2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .overrun(overrun2)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic [9:0] q2[$];

  // Per-frame monitor state.
  logic       slave_en = 1'b0;
  logic [7:0] slave_word = '0;
  int         slave_idx;
  logic       prev_sclk;
  int         rise_cnt, rxv_cnt, rxv_at, rxv_at2, ovr_cnt, ovr_at, ss_bad, busy_bad;
  logic [7:0] mosi_bits;
  logic       ss_at72;
  logic       b2b;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input int i);
    logic [7:0] exp_w;
    if (sclk && !prev_sclk && i < 72) begin
      rise_cnt++;
      mosi_bits = {mosi_bits[6:0], mosi};
    end
    if (!sclk && prev_sclk && slave_en) begin
      slave_idx++;
      if (slave_idx < 8) miso_drv = slave_word[7-slave_idx];
    end
    if (i < 72 && ss !== 1'b0) ss_bad++;
    if (i < 72 && busy !== 1'b1) busy_bad++;
    if (i == 72) ss_at72 = ss;
    if (i == 72 && !b2b && (ss !== 1'b1 || busy !== 1'b0)) begin
      ss_bad++;
      busy_bad++;
    end
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      if (rxv_cnt == 1) rxv_at = i;
      else rxv_at2 = i;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL rx_unexpected: got rx_data=%h at index %0d, required no rx_valid", rx_data, i);
      end else begin
        exp_w = q.pop_front();
        if (rx_data !== exp_w) begin
          n_err++;
          $display("FAIL rx_data: got %h, required %h (index %0d)", rx_data, exp_w, i);
        end
      end
    end
    if (overrun === 1'b1) begin
      ovr_cnt++;
      ovr_at = i;
    end
    prev_sclk = sclk;
  endtask

  // Strobe d at E0; optionally a second strobe sampled at E0+second_at.
  task automatic run_frame(input logic [7:0] d, input int cycles, input int second_at,
                           input logic [7:0] d2);
    rise_cnt = 0; rxv_cnt = 0; rxv_at = -1; rxv_at2 = -1; ovr_cnt = 0; ovr_at = -1;
    ss_bad = 0; busy_bad = 0; mosi_bits = '0; ss_at72 = 1'bx; prev_sclk = 1'b0;
    slave_idx = 0;
    b2b = (second_at == 72);
    if (slave_en) miso_drv = slave_word[7];
    data = d;
    data_update = 1'b1;
    q.push_back(loop ? d : slave_word);
    step();
    observe(0);
    for (int i = 1; i <= cycles; i++) begin
      if (i == second_at) begin
        data = d2;
        data_update = 1'b1;
        if (b2b) q.push_back(d2);
      end else begin
        data_update = 1'b0;
        data = 8'($urandom);
      end
      step();
      observe(i);
    end
    data_update = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({ss, sclk, mosi, busy, rx_valid, overrun} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_ctrl: got ss/sclk/mosi/busy/rxv/ovr=%b, required 100000",
               {ss, sclk, mosi, busy, rx_valid, overrun});
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_rx_data: got %h, required 00", rx_data);
    end
    n_cmp++;
    if ({ss2, sclk2, busy2, rx_data2} !== {3'b100, 10'h000}) begin
      n_err++;
      $display("FAIL reset_dut2: got ss/sclk/busy=%b rx=%h, required 100 rx=000",
               {ss2, sclk2, busy2}, rx_data2);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_loopback();
    loop = 1'b1;
    slave_en = 1'b0;
    run_frame(8'hA5, 90, -1, 8'h00);
    n_cmp++;
    if (rise_cnt != 8) begin
      n_err++; $display("FAIL lb_rises: got %0d, required 8", rise_cnt);
    end
    n_cmp++;
    if (mosi_bits !== 8'hA5) begin
      n_err++; $display("FAIL lb_mosi_bits: got %h, required a5", mosi_bits);
    end
    n_cmp++;
    if (rxv_cnt != 1 || rxv_at != 72) begin
      n_err++; $display("FAIL lb_rx_valid: got %0d pulses at %0d, required 1 at 72", rxv_cnt, rxv_at);
    end
    n_cmp++;
    if (ss_bad != 0 || busy_bad != 0) begin
      n_err++; $display("FAIL lb_ss_busy_window: got %0d/%0d bad cycles, required 0/0", ss_bad, busy_bad);
    end
    n_cmp++;
    if (ovr_cnt != 0) begin
      n_err++; $display("FAIL lb_overrun: got %0d pulses, required 0", ovr_cnt);
    end
  endtask

  task automatic test_slave();
    loop = 1'b0;
    slave_en = 1'b1;
    slave_word = 8'h3C;
    run_frame(8'hFF, 90, -1, 8'h00);
    n_cmp++;
    if (mosi_bits !== 8'hFF) begin
      n_err++; $display("FAIL slave_mosi_bits: got %h, required ff", mosi_bits);
    end
    n_cmp++;
    if (rx_data !== 8'h3C || rxv_at != 72) begin
      n_err++; $display("FAIL slave_rx: got %h at %0d, required 3c at 72", rx_data, rxv_at);
    end
    slave_en = 1'b0;
  endtask

  task automatic test_overrun();
    loop = 1'b1;
    run_frame(8'h12, 150, 11, 8'h99);
    n_cmp++;
    if (ovr_cnt != 1 || ovr_at != 11) begin
      n_err++; $display("FAIL ovr_pulse: got %0d pulses at %0d, required 1 at 11", ovr_cnt, ovr_at);
    end
    n_cmp++;
    if (mosi_bits !== 8'h12 || rxv_cnt != 1) begin
      n_err++; $display("FAIL ovr_frame: got bits %h with %0d frames, required 12 with 1", mosi_bits, rxv_cnt);
    end
    n_cmp++;
    if (busy !== 1'b0 || ss !== 1'b1) begin
      n_err++; $display("FAIL ovr_idle_after: got busy=%b ss=%b, required 0 1", busy, ss);
    end
  endtask

  task automatic test_back_to_back();
    loop = 1'b1;
    run_frame(8'h01, 160, 72, 8'h80);
    n_cmp++;
    if (ovr_cnt != 0) begin
      n_err++; $display("FAIL b2b_overrun: got %0d pulses, required 0", ovr_cnt);
    end
    n_cmp++;
    if (ss_at72 !== 1'b0) begin
      n_err++; $display("FAIL b2b_ss_at72: got %b, required 0", ss_at72);
    end
    n_cmp++;
    if (rxv_cnt != 2 || rxv_at != 72 || rxv_at2 != 144) begin
      n_err++; $display("FAIL b2b_rx_valid: got %0d pulses at %0d,%0d, required 2 at 72,144",
                        rxv_cnt, rxv_at, rxv_at2);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++; $display("FAIL b2b_queue: got %0d pending, required 0", q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    loop = 1'b0;
    slave_en = 1'b1;
    slave_word = 8'hFF;
    run_frame(8'h33, 29, -1, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ss, sclk, busy} !== 3'b100 || rx_data !== 8'h00) begin
      n_err++; $display("FAIL mid_reset_now: got ss/sclk/busy=%b rx=%h, required 100 rx=00",
                        {ss, sclk, busy}, rx_data);
    end
    q.delete();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rx_valid !== 1'b0 || ss !== 1'b1) bad++;
    end
    #2 rst_n = 1'b1;
    step();
    if (rx_valid !== 1'b0) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL mid_reset_quiet: got %0d bad cycles, required 0", bad);
    end
    run_frame(8'h5A, 90, -1, 8'h00);
    n_cmp++;
    if (rx_data !== 8'hFF || rxv_cnt != 1) begin
      n_err++; $display("FAIL mid_reset_fresh: got %h with %0d frames, required ff with 1", rx_data, rxv_cnt);
    end
    slave_en = 1'b0;
  endtask

  task automatic test_div1_width10();
    int   got_at;
    logic busy_at21;
    logic [9:0] exp_w;
    got_at = -1;
    busy_at21 = 1'bx;
    data2 = 10'h2B3;
    data_update2 = 1'b1;
    q2.push_back(10'h2B3);
    step();
    data_update2 = 1'b0;
    for (int i = 1; i <= 60 && got_at < 0; i++) begin
      data2 = 10'($urandom);
      step();
      if (i == 21) busy_at21 = busy2;
      if (rx_valid2 === 1'b1) begin
        got_at = i;
        exp_w = q2.pop_front();
        n_cmp++;
        if (rx_data2 !== exp_w) begin
          n_err++; $display("FAIL div1_rx_data: got %h, required %h", rx_data2, exp_w);
        end
      end
    end
    n_cmp++;
    if (got_at != 22) begin
      n_err++; $display("FAIL div1_frame_len: got %0d, required 22", got_at);
    end
    n_cmp++;
    if (busy_at21 !== 1'b1 || busy2 !== 1'b0) begin
      n_err++; $display("FAIL div1_busy: got %b at 21 and %b at end, required 1 and 0", busy_at21, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_div1_width10();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
